// File: rtl/spwf_pkg.sv
// Shared constants, clear-engine state type and byte-parity helper for the spwf RAM.
// The optional per-byte parity in spwf_ram_param is enabled by the SPWF_PARITY_EN macro.
package spwf_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Even parity: the stored bit makes the total count of ones in byte+bit even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/spwf_clear_engine.sv
// Clear engine: sweeps every address once, from 0 upward, after reset release or on init_start.
// While it runs, busy is high and the RAM refuses external accesses.
module spwf_clear_engine
  import spwf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  init_start,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_t             state;
  logic                   boot_pending;
  logic [ADDR_WIDTH-1:0]  count;

  // boot_pending resets to 1 so the first edge after reset release starts a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      boot_pending <= 1'b1;
      count        <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (boot_pending || init_start) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            boot_pending <= 1'b0;
            count        <= '0;
          end
        end
        CLEAR: begin
          // Terminal count compared directly, so the counter never wraps; init_start is ignored here.
          if (count == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_addr = count;

endmodule

// File: rtl/spwf_ram_param.sv
// Single-port, write-first, byte-enabled RAM with a built-in clear engine and optional output register.
// Define SPWF_PARITY_EN to store and check one even-parity bit per byte.
module spwf_ram_param
  import spwf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int OUT_REG    = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH/8-1:0] byte_enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  input  logic                    init_start,
  output logic                    init_busy,
  output logic                    parity_error
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  accept;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  rd_perr;

  spwf_clear_engine #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .clock      (clock),
    .reset_n    (reset_n),
    .init_start (init_start),
    .busy       (init_busy),
    .clr_addr   (clr_addr)
  );

  assign accept   = enable && !init_busy;
  assign old_word = mem[address];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    merged = old_word;
    for (int b = 0; b < NB; b++) begin
      if (byte_enable[b]) merged[b*8 +: 8] = data_in[b*8 +: 8];
    end
  end

  // NOTE: the array has no reset; it is zeroed only by the clear engine sweeping it.
  always_ff @(posedge clock) begin
    if (init_busy) begin
      mem[clr_addr] <= '0;
    end else if (accept && write_enable) begin
      mem[address] <= merged;
    end
  end

`ifdef SPWF_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par;
  logic [NB-1:0] zero_par;

  always_comb begin
    wr_par   = '0;
    rd_par   = '0;
    zero_par = '0;
    for (int b = 0; b < NB; b++) begin
      wr_par[b]   = byte_parity(merged[b*8 +: 8]);
      rd_par[b]   = byte_parity(old_word[b*8 +: 8]);
      zero_par[b] = byte_parity(8'h00);
    end
  end

  always_ff @(posedge clock) begin
    if (init_busy) begin
      par_mem[clr_addr] <= zero_par;
    end else if (accept && write_enable) begin
      par_mem[address] <= wr_par;
    end
  end

  assign rd_perr = (rd_par != par_mem[address]);
`else
  assign rd_perr = 1'b0;
`endif

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_perr;

  // s1_data only moves on an accepted access, so data_out holds between accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_perr  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_perr  <= accept && !write_enable && rd_perr;
      if (accept) s1_data <= write_enable ? merged : old_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_perr;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_perr  <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_perr  <= s1_perr;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign data_out     = s2_data;
      assign data_valid   = s2_valid;
      assign parity_error = s2_perr;
    end else begin : g_no_out_reg
      assign data_out     = s1_data;
      assign data_valid   = s1_valid;
      assign parity_error = s1_perr;
    end
  endgenerate

endmodule
